// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: datapath width, canonical NOP, reset PC and
// the fetch queue entry layout.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic            busy;
    logic            filled;
    logic            misaligned;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

  localparam fq_entry_t EMPTY_ENTRY = '{busy: 1'b0, filled: 1'b0, misaligned: 1'b0,
                                        pc: '0, instr: '0};

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// PC-tagged ring buffer for the fetch queue: allocate at alloc, fill responses
// in order at fill, pop at head. Flush empties everything in one cycle.
module fetch_buffer
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    alloc_en,
  input  logic                    alloc_misaligned,
  input  logic [XLEN-1:0]         alloc_pc,
  input  logic                    fill_en,
  input  logic [XLEN-1:0]         fill_instr,
  input  logic                    pop_en,
  output logic                    head_valid,
  output logic [XLEN-1:0]         head_pc,
  output logic [XLEN-1:0]         head_instr,
  output logic                    head_misaligned,
  output logic [$clog2(DEPTH):0]  count,
  output logic [$clog2(DEPTH):0]  pending,
  output logic                    fill_at_alloc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fq_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] alloc_q, alloc_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    alloc_d = alloc_q;
    fill_d  = fill_q;
    count_d = count_q;
    if (flush) begin
      ent_d   = '0;
      head_d  = '0;
      alloc_d = '0;
      fill_d  = '0;
      count_d = '0;
    end else begin
      if (fill_en) begin
        ent_d[fill_q].instr  = fill_instr;
        ent_d[fill_q].filled = 1'b1;
        fill_d               = fill_q + PW'(1);
      end
      if (pop_en) begin
        ent_d[head_q] = EMPTY_ENTRY;
        head_d        = head_q + PW'(1);
      end
      if (alloc_en) begin
        ent_d[alloc_q].busy       = 1'b1;
        ent_d[alloc_q].filled     = alloc_misaligned;
        ent_d[alloc_q].misaligned = alloc_misaligned;
        ent_d[alloc_q].pc         = alloc_pc;
        ent_d[alloc_q].instr      = alloc_misaligned ? NOP_INSTR : '0;
        alloc_d                   = alloc_q + PW'(1);
        // A misaligned entry is born filled, so the fill pointer skips past it.
        if (alloc_misaligned) fill_d = fill_q + PW'(1);
      end
      count_d = count_q + CW'(alloc_en) - CW'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ent_q   <= '0;
      head_q  <= '0;
      alloc_q <= '0;
      fill_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].busy && !ent_q[i].filled) pending = pending + CW'(1);
    end
  end

  assign head_valid      = ent_q[head_q].filled;
  assign head_pc         = ent_q[head_q].pc;
  assign head_instr      = ent_q[head_q].instr;
  assign head_misaligned = ent_q[head_q].misaligned;
  assign count           = count_q;
  assign fill_at_alloc   = (fill_q == alloc_q);

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues word requests for pc_current, buffers the
// in-order responses and hands {pc, instr} to decode; redirects drop stale data.
module fetch_queue
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_current,
  output logic            pc_advance,
  input  logic            redirect,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            id_misaligned
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count, pending;
  logic          fill_at_alloc, head_valid;
  logic          can_alloc, mis_alloc, rsp_keep, pop;

  assign can_alloc      = reset && !redirect && (count < CW'(DEPTH)) && (drop_q == '0);
  assign imem_req_valid = can_alloc && is_word_aligned(pc_current);
  assign imem_req_addr  = pc_current;
  assign pc_advance     = imem_req_valid && imem_req_ready;
  // Wait for outstanding fetches to land so the fault entry stays in program order.
  assign mis_alloc      = can_alloc && !is_word_aligned(pc_current) && fill_at_alloc;
  assign rsp_keep       = imem_rsp_valid && !redirect && (drop_q == '0);
  assign id_valid       = head_valid && !redirect;
  assign pop            = id_valid && id_ready;

  always_comb begin
    drop_d = drop_q;
    if (redirect) begin
      // Everything still in flight is stale; a response landing now retires one of them.
      drop_d = drop_q + pending - CW'(imem_rsp_valid);
    end else if (imem_rsp_valid && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk              (clk),
    .reset            (reset),
    .flush            (redirect),
    .alloc_en         (pc_advance || mis_alloc),
    .alloc_misaligned (mis_alloc),
    .alloc_pc         (pc_current),
    .fill_en          (rsp_keep),
    .fill_instr       (imem_rsp_data),
    .pop_en           (pop),
    .head_valid       (head_valid),
    .head_pc          (id_pc),
    .head_instr       (id_instr),
    .head_misaligned  (id_misaligned),
    .count            (count),
    .pending          (pending),
    .fill_at_alloc    (fill_at_alloc)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based model
// of the fetch buffer, a fixed-latency memory and the pc register.
module tb_fetch_queue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_current = '0;
  logic        pc_advance;
  logic        redirect = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_misaligned;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_current     (pc_current),
    .pc_advance     (pc_advance),
    .redirect       (redirect),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_misaligned  (id_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          filled;
    bit          mis;
  } m_ent_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } m_rsp_t;

  m_ent_t      mq[$];
  m_rsp_t      mem[$];
  int          drop = 0;
  int          lat = 1;
  int          cyc = 0;
  bit          known = 0;
  logic [31:0] pc_reg = '0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic step(input bit rst_b, input bit redir, input logic [31:0] tgt,
                      input bit rq_rdy, input bit idr);
    bit          rsp, e_req, e_adv, e_idv, e_mis;
    logic [31:0] rdata;
    int          cnt, unf, cur;
    @(negedge clk);
    cur = cyc;
    reset = rst_b;
    redirect = redir;
    imem_req_ready = rq_rdy;
    id_ready = idr;
    pc_current = pc_reg;
    rsp = (mem.size() > 0) && (mem[0].due == cur);
    rdata = rsp ? mem[0].data : $urandom;
    imem_rsp_valid = rsp;
    imem_rsp_data = rdata;
    #1;
    cnt = mq.size();
    unf = 0;
    foreach (mq[i]) if (!mq[i].filled) unf++;
    e_req = rst_b && !redir && cnt < DEPTH && drop == 0 && pc_reg[1:0] == 2'b00;
    e_adv = e_req && rq_rdy;
    e_idv = !redir && cnt > 0 && mq[0].filled;
    e_mis = rst_b && !redir && cnt < DEPTH && drop == 0 && pc_reg[1:0] != 2'b00 && unf == 0;
    if (known) begin
      check("req_valid", 32'(imem_req_valid), 32'(e_req));
      check("pc_advance", 32'(pc_advance), 32'(e_adv));
      check("req_addr", imem_req_addr, pc_reg);
      check("id_valid", 32'(id_valid), 32'(e_idv));
      if (e_idv) begin
        check("id_pc", id_pc, mq[0].pc);
        check("id_instr", id_instr, mq[0].instr);
        check("id_misaligned", 32'(id_misaligned), 32'(mq[0].mis));
      end
      if (!rst_b && cnt == 0) begin
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_instr", id_instr, 32'h0);
        check("rst_id_mis", 32'(id_misaligned), 32'h0);
      end
    end
    @(posedge clk);
    cyc++;
    if (rsp) void'(mem.pop_front());
    if (!rst_b) begin
      mq.delete();
      mem.delete();
      drop = 0;
      known = 1;
    end else if (redir) begin
      drop = drop + unf - (rsp ? 1 : 0);
      mq.delete();
    end else begin
      if (rsp) begin
        if (drop > 0) drop--;
        else begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].filled) begin
              mq[i].instr = rdata;
              mq[i].filled = 1;
              break;
            end
          end
        end
      end
      if (e_idv && idr) void'(mq.pop_front());
      if (e_adv) begin
        mq.push_back('{pc: pc_reg, instr: 32'h0, filled: 0, mis: 0});
        mem.push_back('{due: cur + lat, data: pc_reg + 32'h100});
      end else if (e_mis) begin
        mq.push_back('{pc: pc_reg, instr: 32'h0000_0013, filled: 1, mis: 1});
      end
    end
    if (redir) pc_reg = tgt;
    else if (e_adv) pc_reg = pc_reg + 32'd4;
  endtask

  initial begin
    logic [31:0] t;
    bit          rb, rd;
    // streaming from pc 0 with 1-cycle memory
    lat = 1;
    pc_reg = 32'h0;
    repeat (2) step(0, 0, 0, 1, 1);
    repeat (12) step(1, 0, 0, 1, 1);
    // decode backpressure
    repeat (5) step(1, 0, 0, 1, 0);
    repeat (6) step(1, 0, 0, 1, 1);
    // redirect with two outstanding fetches on 3-cycle memory
    lat = 3;
    pc_reg = 32'h0;
    step(0, 0, 0, 1, 1);
    repeat (2) step(1, 0, 0, 1, 1);
    step(1, 1, 32'h40, 1, 1);
    repeat (10) step(1, 0, 0, 1, 1);
    // redirect while responses are streaming back
    step(1, 1, 32'h100, 1, 1);
    repeat (10) step(1, 0, 0, 1, 1);
    // misaligned target
    step(1, 1, 32'h6, 1, 1);
    repeat (8) step(1, 0, 0, 1, 0);
    repeat (4) step(1, 0, 0, 1, 1);
    step(1, 1, 32'h200, 1, 1);
    repeat (8) step(1, 0, 0, 1, 1);
    // reset with entries buffered
    lat = 1;
    step(0, 0, 0, 1, 1);
    repeat (4) step(1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    repeat (8) step(1, 0, 0, 1, 1);
    // randomized traffic at each memory latency
    for (int l = 1; l <= 3; l++) begin
      lat = l;
      repeat (2) step(0, 0, 0, 1, 1);
      for (int k = 0; k < 600; k++) begin
        rb = ($urandom_range(0, 999) >= 5);
        rd = ($urandom_range(0, 99) < 4);
        t = 32'($urandom_range(0, 1023)) << 2;
        if ($urandom_range(0, 99) < 15) t = t | 32'($urandom_range(1, 3));
        step(rb, rd, t, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
